pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Central hazard and sequencing controller for the 5-stage vector pipeline (F, D, E, M, W).
- Drives stall and flush enables on the pipeline registers, including the D→E register.
- Selects operand forwarding into E.
- Sequences multi-cycle vector operations that hold the E stage for several cycles, and freezes the pipeline while data memory is not ready.

## Interface
Parameters:
- REG_AW, 4, register-address width
- OPC_W, 4, opcode width
- MULTI_OPC, 4'hC, opcode of the multi-cycle vector op
- MULTI_CYC, 6, cycles the multi-cycle op occupies E (legal 2..8)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ra1D, ra2D  in  REG_AW  source registers of the instruction in D
- ra1E, ra2E  in  REG_AW  source registers of the instruction in E
- WA3E  in  REG_AW  destination register in E
- regWriteE, memToRegE, PCSrcE  in  1  E-stage control bits (PCSrcE = taken branch)
- opcodeE  in  OPC_W  opcode in E
- WA3M  in  REG_AW  destination register in M
- regWriteM  in  1  register-write enable in M
- memReqM  in  1  load or store in M
- memReadyM  in  1  memory completes this cycle
- WA3W  in  REG_AW  destination register in W
- regWriteW  in  1  register-write enable in W
- stallF, stallD, stallE, stallM  out  1  hold the corresponding stage register
- flushD, flushE, flushM, flushW  out  1  load a bubble into the corresponding stage register
- forwardAE, forwardBE  out  2  operand select: 00 RF, 01 W result, 10 M result
- laneE  out  3  current lane index of the multi-cycle op
- busy  out  1  state≠RUN or memory stall

## Operation
- FSM states: RUN, MULTI. A 3-bit lane counter drives laneE.
- memStall = memReqM & ~memReadyM. This has the highest priority:
  - stallF/D/E/M = 1, flushW = 1.
  - All other flushes = 0.
  - FSM and counter hold.
  - Forward selects are still computed.
- MULTI entry: RUN, no memStall, opcodeE == MULTI_OPC.
  - Outputs: stallF/D/E = 1, flushM = 1, laneE = 0.
  - Next state MULTI, lane = 1.
- In MULTI, no memStall, lane < MULTI_CYC-1:
  - Same stalls and flushM; lane increments.
- In MULTI, lane == MULTI_CYC-1:
  - No stalls, no flushM; result advances to M.
  - Next state RUN, lane = 0.
- In MULTI, PCSrcE and load-use detection are ignored.
- In RUN, no memStall, not a multi-cycle op:
  - PCSrcE: flushD = 1 and flushE = 1, no stalls. This takes precedence over load-use.
  - Otherwise load-use hazard, i.e. regWriteE & memToRegE & (WA3E == ra1D | WA3E == ra2D): stallF = 1, stallD = 1, flushE = 1.
- Forwarding, computed per operand (shown for A; B uses ra2E):
  - 10 if regWriteM & WA3M == ra1E.
  - Else 01 if regWriteW & WA3W == ra1E.
  - Else 00.
  - M has priority over W.
- Register 0 is not special-cased.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the registered state, valid in the same cycle.
- Reset:
  - state = RUN, lane = 0, immediately on rst rising.
  - While rst = 1, all stall/flush outputs, forwardAE/BE, laneE and busy are forced to 0.
- Reset mid-MULTI aborts the op; no further stall cycles follow.
- The multi-cycle op occupies E for exactly MULTI_CYC unstalled cycles. Each memStall cycle adds one cycle.
- Load-use costs exactly one bubble. Taken branch costs two flushed slots.
- memStall and PCSrcE in the same cycle: the flush is deferred until memStall drops; PCSrcE is still held in E.

## Configuration
- HAZARD_FWD_EN defined: forwarding and the single-bubble load-use rule exactly as above.
- HAZARD_FWD_EN undefined:
  - forwardAE/BE are tied to 00.
  - In RUN, any RAW hazard stalls: (regWriteE & WA3E ∈ {ra1D, ra2D}) | (regWriteM & WA3M ∈ {ra1D, ra2D}) gives stallF = 1, stallD = 1, flushE = 1.
  - W is not checked; the register file is write-through.

## Structure
- Package pipe_ctrl_pkg holds:
  - enum ctrl_state_t {RUN, MULTI}
  - forward-select constants FWD_RF, FWD_W, FWD_M
  - default MULTI_OPC
- Sub-module pipe_fwd_unit: purely combinational comparator that computes forwardAE/BE. It is instantiated only under HAZARD_FWD_EN.

## Test plan
- Forwarding:
  - ra1E = 3, regWriteM = 1, WA3M = 3, regWriteW = 1, WA3W = 3 → forwardAE = 10.
  - Then regWriteM = 0 → forwardAE = 01.
- Load-use: memToRegE = regWriteE = 1, WA3E = 5, ra2D = 5 → one cycle of stallF = stallD = flushE = 1, then all 0.
- Multi-cycle op:
  - opcodeE = 4'hC with MULTI_CYC = 6 → stallE high for 5 cycles, laneE runs 0..5, busy high for cycles 2–6.
  - Sixth cycle has no stalls; state returns to RUN.
- memStall during MULTI at lane = 2, memReadyM low for 3 cycles → lane holds at 2, all stalls and flushW high, the op then completes 3 cycles late.
- Branch with memStall: PCSrcE = 1 together with memReqM = 1, memReadyM = 0 for 2 cycles → flushD/flushE stay 0 for 2 cycles, then pulse for 1 cycle.
- Reset: rst asserted at lane = 3 in MULTI → outputs 0 immediately; after release state is RUN and laneE = 0.
- Without HAZARD_FWD_EN: regWriteM = 1, WA3M = 7, ra1D = 7 → stallF = stallD = flushE = 1 and forwardAE = 00.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the vector-pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    MULTI = 1'b1
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] DEF_MULTI_OPC = 4'hC;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational E-stage operand forwarding select; M result wins over W result.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic              regWriteM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              regWriteW,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE
);

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] ra,
                                         input logic [REG_AW-1:0] wa_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] wa_w,
                                         input logic              we_w);
    if (we_m && (wa_m == ra))      return FWD_M;
    else if (we_w && (wa_w == ra)) return FWD_W;
    else                           return FWD_RF;
  endfunction

  always_comb begin
    forwardAE = fwd_sel(ra1E, WA3M, regWriteM, WA3W, regWriteW);
    forwardBE = fwd_sel(ra2E, WA3M, regWriteM, WA3W, regWriteW);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage vector pipeline with a
// multi-cycle E-stage sequencer. Define HAZARD_FWD_EN to enable forwarding.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int               REG_AW    = 4,
  parameter int               OPC_W     = 4,
  parameter logic [OPC_W-1:0] MULTI_OPC = OPC_W'(DEF_MULTI_OPC),
  parameter int               MULTI_CYC = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic              PCSrcE,
  input  logic [OPC_W-1:0]  opcodeE,
  input  logic [REG_AW-1:0] WA3M,
  input  logic              regWriteM,
  input  logic              memReqM,
  input  logic              memReadyM,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              regWriteW,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic [2:0]        laneE,
  output logic              busy
);

  localparam logic [2:0] LANE_LAST = 3'(MULTI_CYC - 1);

  ctrl_state_t r_state;
  logic [2:0]  r_lane;

  logic       w_mem_stall;
  logic       w_is_multi;
  logic       w_raw;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_mem_stall = memReqM & ~memReadyM;
  assign w_is_multi  = (opcodeE == MULTI_OPC);

`ifdef HAZARD_FWD_EN
  // Only a load in E cannot be forwarded in time; everything else is bypassed.
  assign w_raw = regWriteE & memToRegE & ((WA3E == ra1D) | (WA3E == ra2D));

  pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd (
    .ra1E      (ra1E),
    .ra2E      (ra2E),
    .WA3M      (WA3M),
    .regWriteM (regWriteM),
    .WA3W      (WA3W),
    .regWriteW (regWriteW),
    .forwardAE (w_fwd_a),
    .forwardBE (w_fwd_b)
  );
`else
  // Without bypass, any pending write in E or M blocks D; W writes through the RF.
  assign w_raw = (regWriteE & ((WA3E == ra1D) | (WA3E == ra2D)))
               | (regWriteM & ((WA3M == ra1D) | (WA3M == ra2D)));
  assign w_fwd_a = FWD_RF;
  assign w_fwd_b = FWD_RF;

  logic w_unused;
  assign w_unused = ^{ra1E, ra2E, WA3W, regWriteW, memToRegE};
`endif

  // NOTE: every output gets a default first so the priority chain below cannot infer a latch.
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    laneE     = 3'd0;
    busy      = 1'b0;
    if (!rst) begin
      forwardAE = w_fwd_a;
      forwardBE = w_fwd_b;
      laneE     = r_lane;
      busy      = (r_state != RUN) | w_mem_stall;
      if (w_mem_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (r_state == MULTI) begin
        if (r_lane != LANE_LAST) begin
          stallF = 1'b1;
          stallD = 1'b1;
          stallE = 1'b1;
          flushM = 1'b1;
        end
      end else if (w_is_multi) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (PCSrcE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (w_raw) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_lane  <= 3'd0;
    end else if (!w_mem_stall) begin
      case (r_state)
        RUN: begin
          if (w_is_multi) begin
            r_state <= MULTI;
            r_lane  <= 3'd1;
          end
        end
        MULTI: begin
          if (r_lane == LANE_LAST) begin
            r_state <= RUN;
            r_lane  <= 3'd0;
          end else begin
            r_lane <= r_lane + 3'd1;
          end
        end
        default: begin
          r_state <= RUN;
          r_lane  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W, opcodeE;
  logic       regWriteE, memToRegE, PCSrcE, regWriteM, memReqM, memReadyM, regWriteW;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic [1:0] forwardAE, forwardBE;
  logic [2:0] laneE;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ra1D      (ra1D),
    .ra2D      (ra2D),
    .ra1E      (ra1E),
    .ra2E      (ra2E),
    .WA3E      (WA3E),
    .regWriteE (regWriteE),
    .memToRegE (memToRegE),
    .PCSrcE    (PCSrcE),
    .opcodeE   (opcodeE),
    .WA3M      (WA3M),
    .regWriteM (regWriteM),
    .memReqM   (memReqM),
    .memReadyM (memReadyM),
    .WA3W      (WA3W),
    .regWriteW (regWriteW),
    .stallF    (stallF),
    .stallD    (stallD),
    .stallE    (stallE),
    .stallM    (stallM),
    .flushD    (flushD),
    .flushE    (flushE),
    .flushM    (flushM),
    .flushW    (flushW),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE),
    .laneE     (laneE),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Control word: {stallF,stallD,stallE,stallM, flushD,flushE,flushM,flushW, laneE, busy}
  task automatic chk_ctrl(input string tag, input logic [3:0] stl, input logic [3:0] fls,
                          input logic [2:0] lane, input logic bsy);
    check(tag, {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, laneE, busy},
          {stl, fls, lane, bsy});
  endtask

  task automatic chk_fwd(input string tag, input logic [3:0] fwd);
    check(tag, {8'd0, forwardAE, forwardBE}, {8'd0, fwd});
  endtask

  task automatic clr();
    ra1D = 0; ra2D = 0; ra1E = 0; ra2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    opcodeE = 0; regWriteE = 0; memToRegE = 0; PCSrcE = 0; regWriteM = 0;
    memReqM = 0; memReadyM = 0; regWriteW = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    clr();
    memReqM = 1; regWriteM = 1; WA3M = 3; ra1E = 3; opcodeE = 4'hC;
    #1;
    chk_ctrl("rst_ctrl", 4'b0000, 4'b0000, 3'd0, 1'b0);
    chk_fwd("rst_fwd", 4'b0000);
    repeat (2) tick();
    tick(); rst = 0; clr(); #1;
    chk_ctrl("idle", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // Forwarding priority
    tick(); ra1E = 3; regWriteM = 1; WA3M = 3; regWriteW = 1; WA3W = 3; #1;
    chk_fwd("fwd_m_over_w", FWD_EN ? 4'b1000 : 4'b0000);
    chk_ctrl("fwd_no_stall", 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick(); regWriteM = 0; #1;
    chk_fwd("fwd_w", FWD_EN ? 4'b0100 : 4'b0000);
    tick(); regWriteM = 1; WA3M = 4; ra1E = 4; ra2E = 3; #1;
    chk_fwd("fwd_a_m_b_w", FWD_EN ? 4'b1001 : 4'b0000);

    // Load-use: exactly one bubble
    tick(); clr(); regWriteE = 1; memToRegE = 1; WA3E = 5; ra2D = 5; #1;
    chk_ctrl("lu_hit", 4'b1100, 4'b0100, 3'd0, 1'b0);
    tick(); regWriteE = 0; memToRegE = 0; #1;
    chk_ctrl("lu_after", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // Taken branch wins over load-use
    tick(); regWriteE = 1; memToRegE = 1; WA3E = 5; ra2D = 5; PCSrcE = 1; #1;
    chk_ctrl("br_over_lu", 4'b0000, 4'b1100, 3'd0, 1'b0);

    // Multi-cycle op, MULTI_CYC = 6
    tick(); clr(); opcodeE = 4'hC; #1;
    chk_ctrl("multi_l0", 4'b1110, 4'b0010, 3'd0, 1'b0);
    tick(); #1; chk_ctrl("multi_l1", 4'b1110, 4'b0010, 3'd1, 1'b1);
    tick(); #1; chk_ctrl("multi_l2", 4'b1110, 4'b0010, 3'd2, 1'b1);
    tick(); PCSrcE = 1; #1;
    chk_ctrl("multi_l3_br_ignored", 4'b1110, 4'b0010, 3'd3, 1'b1);
    tick(); PCSrcE = 0; regWriteE = 1; memToRegE = 1; WA3E = 5; ra1D = 5; #1;
    chk_ctrl("multi_l4_lu_ignored", 4'b1110, 4'b0010, 3'd4, 1'b1);
    tick(); regWriteE = 0; memToRegE = 0; #1;
    chk_ctrl("multi_l5_last", 4'b0000, 4'b0000, 3'd5, 1'b1);
    tick(); opcodeE = 0; #1;
    chk_ctrl("multi_done", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // Memory stall in the middle of a multi-cycle op
    tick(); clr(); opcodeE = 4'hC; #1;
    chk_ctrl("ms_l0", 4'b1110, 4'b0010, 3'd0, 1'b0);
    tick(); #1; chk_ctrl("ms_l1", 4'b1110, 4'b0010, 3'd1, 1'b1);
    tick(); memReqM = 1; memReadyM = 0; #1;
    chk_ctrl("ms_l2_hold0", 4'b1111, 4'b0001, 3'd2, 1'b1);
    tick(); #1; chk_ctrl("ms_l2_hold1", 4'b1111, 4'b0001, 3'd2, 1'b1);
    tick(); #1; chk_ctrl("ms_l2_hold2", 4'b1111, 4'b0001, 3'd2, 1'b1);
    tick(); memReadyM = 1; #1;
    chk_ctrl("ms_l2_release", 4'b1110, 4'b0010, 3'd2, 1'b1);
    tick(); memReqM = 0; #1; chk_ctrl("ms_l3", 4'b1110, 4'b0010, 3'd3, 1'b1);
    tick(); #1; chk_ctrl("ms_l4", 4'b1110, 4'b0010, 3'd4, 1'b1);
    tick(); #1; chk_ctrl("ms_l5_last", 4'b0000, 4'b0000, 3'd5, 1'b1);
    tick(); opcodeE = 0; #1;
    chk_ctrl("ms_done", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // Branch deferred by a memory stall
    tick(); PCSrcE = 1; memReqM = 1; memReadyM = 0; #1;
    chk_ctrl("br_ms0", 4'b1111, 4'b0001, 3'd0, 1'b1);
    tick(); #1; chk_ctrl("br_ms1", 4'b1111, 4'b0001, 3'd0, 1'b1);
    tick(); memReadyM = 1; #1;
    chk_ctrl("br_fire", 4'b0000, 4'b1100, 3'd0, 1'b0);
    tick(); clr(); #1;
    chk_ctrl("br_after", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // Memory stall blocks multi entry, then reset aborts the op at lane 3
    tick(); opcodeE = 4'hC; memReqM = 1; memReadyM = 0; #1;
    chk_ctrl("ms_entry_blocked", 4'b1111, 4'b0001, 3'd0, 1'b1);
    tick(); memReqM = 0; #1; chk_ctrl("rs_l0", 4'b1110, 4'b0010, 3'd0, 1'b0);
    tick(); #1; chk_ctrl("rs_l1", 4'b1110, 4'b0010, 3'd1, 1'b1);
    tick(); #1; chk_ctrl("rs_l2", 4'b1110, 4'b0010, 3'd2, 1'b1);
    tick(); #1; chk_ctrl("rs_l3", 4'b1110, 4'b0010, 3'd3, 1'b1);
    #1; rst = 1; #1;
    chk_ctrl("rst_mid_multi", 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick(); rst = 0; opcodeE = 0; #1;
    chk_ctrl("rst_release", 4'b0000, 4'b0000, 3'd0, 1'b0);
    tick(); #1;
    chk_ctrl("rst_no_tail", 4'b0000, 4'b0000, 3'd0, 1'b0);

    // RAW on M result: stall without forwarding, bypass with it
    tick(); regWriteM = 1; WA3M = 7; ra1D = 7; ra1E = 7; #1;
    chk_ctrl("raw_m", FWD_EN ? 4'b0000 : 4'b1100, FWD_EN ? 4'b0000 : 4'b0100, 3'd0, 1'b0);
    chk_fwd("raw_m_fwd", FWD_EN ? 4'b1000 : 4'b0000);
    tick(); clr(); regWriteW = 1; WA3W = 6; ra2D = 6; #1;
    chk_ctrl("w_not_checked", 4'b0000, 4'b0000, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
